uart_tx_frame_gen: RTL and testbench
====================================

Name: uart_tx_frame_gen

Overview:
Parametrised UART transmit frame generator. It replaces the stand-alone parity register with a complete frame serializer that has configurable data width, four parity modes plus parity-off, and 1 or 2 stop bits. It sits in the UART TX path on the baud-rate clock domain, fed by the synchronised TX FIFO / data-sync output. Each clk cycle is one bit period.

Parameters:
DATA_WIDTH, 8, payload bits per frame (>=5); sets width of p_data and of the bit counter (clog2(DATA_WIDTH)).

Ports:
clk  input  1  baud-rate clock, one bit time per cycle
rst_n  input  1  asynchronous active-low reset
p_data  input  DATA_WIDTH  parallel payload, sampled on accept
data_valid  input  1  payload valid; request to send
par_en  input  1  1 = insert parity bit; sampled on accept
par_mode  input  2  00 even, 01 odd, 10 mark (1), 11 space (0); sampled on accept
stop2  input  1  1 = two stop bits, 0 = one; sampled on accept
tx_out  output  1  serial line, idle high
busy  output  1  high while a frame is on the line (START through final STOP)
ready  output  1  accept window: high in IDLE and in the final STOP cycle
tx_done  output  1  one-cycle pulse in the cycle after the final stop bit completes, unless a new frame was accepted in that final stop cycle

Behaviour:
- Clock is clk; reset is asynchronous, active-low rst_n. All outputs are registered except ready, which is decoded from state.
- Reset values: tx_out=1, busy=0, tx_done=0, state=IDLE, shift reg=0, bit counter=0, parity=0. Reset asserted mid-frame aborts immediately: line goes high and state returns to IDLE. Nothing is retained.
- Accept: data_valid=1 && ready=1 at a rising edge. On that edge, latch p_data, par_en, par_mode and stop2, and compute the parity bit: even = ^p_data; odd = ~^p_data; mark = 1; space = 0. data_valid while ready=0 is ignored; no queuing.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: tx_out=1, busy=0. On accept, go to START.
- START: tx_out=0, busy=1. Go to DATA with counter=0.
- DATA: tx_out=shift[0], LSB first. Shift right each cycle. After DATA_WIDTH cycles (counter==DATA_WIDTH-1), go to PARITY if par_en, else STOP1.
- PARITY: tx_out=latched parity bit. Go to STOP1.
- STOP1: tx_out=1. If stop2, go to STOP2. Otherwise this is the final stop cycle.
- STOP2: tx_out=1. Always the final stop cycle.
- Final stop cycle: ready=1. With an accept, go directly to START (back-to-back frames, no idle gap); busy stays 1 and no tx_done pulse. Without an accept, go to IDLE with tx_done=1 for one cycle.
- Latency: accept edge -> start bit on tx_out in the next cycle.
- Frame length = 1 + DATA_WIDTH + par_en + (stop2 ? 2 : 1) cycles.
- Inputs change mid-frame: no effect. Only latched values are used.
- Parity is computed over all DATA_WIDTH bits; there are no partial-width modes.

Test Plan:
- Reset mid-DATA of a frame -> tx_out=1, busy=0, tx_done=0 within the reset assertion. After release, the next accept sends a clean frame from START.
- DATA_WIDTH=8, p_data=0xA5, par_en=1, par_mode=00, stop2=0 -> tx_out sequence 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop). busy is high for 11 cycles, then tx_done pulses once.
- Same data, par_mode=01 -> parity slot=1. par_mode=10 with p_data=0x00 -> parity slot=1. par_mode=11 with p_data=0xFF -> parity slot=0.
- par_en=0, stop2=1, p_data=0x3C -> 0,0,0,1,1,1,1,0,0,1,1: 11 bits with no parity slot and two stop bits. ready is high only in the second stop cycle.
- Back-to-back: hold data_valid=1 with 0x55 then 0xAA, presented in the final stop cycle -> the next cycle is a start bit, busy never drops, and there is no tx_done pulse between frames. data_valid pulsed during DATA -> ignored, and the frame is unchanged.

Source files
------------

// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame serializer: START, LSB-first payload, optional parity, 1 or 2 STOP bits.
// One clk cycle is one bit period; back-to-back frames are accepted in the final stop cycle.
module uart_tx_frame_gen #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic [1:0]            par_mode,
  input  logic                  stop2,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  ready,
  output logic                  tx_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic [1:0]            mode);
    logic p;
    case (mode)
      2'b00:   p = ^data;
      2'b01:   p = ~^data;
      2'b10:   p = 1'b1;
      2'b11:   p = 1'b0;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  state_t                state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_nxt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
  logic                  par_en_r, par_bit_r, stop2_r;
  logic                  tx_out_r, busy_r, tx_done_r;
  logic                  tx_nxt_s, final_stop_s, accept_s;

  assign final_stop_s = (state_r == STOP2) || ((state_r == STOP1) && !stop2_r);
  assign ready        = (state_r == IDLE) || final_stop_s;
  assign accept_s     = data_valid && ready;

  assign tx_out  = tx_out_r;
  assign busy    = busy_r;
  assign tx_done = tx_done_r;

  // Next-state, shifter and counter decode; line level is decoded from the next state
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    cnt_nxt_s   = cnt_r;
    tx_nxt_s    = 1'b1;

    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = START;
        else          state_nxt_s = IDLE;
      end
      START: begin
        state_nxt_s = DATA;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
      DATA: begin
        shift_nxt_s = shift_r >> 1;
        if (cnt_r == LAST_CNT) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          if (par_en_r) state_nxt_s = PARITY;
          else          state_nxt_s = STOP1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      PARITY: state_nxt_s = STOP1;
      STOP1: begin
        if (stop2_r)       state_nxt_s = STOP2;
        else if (accept_s) state_nxt_s = START;
        else               state_nxt_s = IDLE;
      end
      STOP2: begin
        if (accept_s) state_nxt_s = START;
        else          state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase

    // Accept only happens in IDLE or a final stop cycle, never while shifting
    if (accept_s) shift_nxt_s = p_data;
    else          shift_nxt_s = shift_nxt_s;

    case (state_nxt_s)
      START:   tx_nxt_s = 1'b0;
      DATA:    tx_nxt_s = shift_nxt_s[0];
      PARITY:  tx_nxt_s = par_bit_r;
      default: tx_nxt_s = 1'b1;
    endcase
  end

  // State, datapath and registered line outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      shift_r   <= {DATA_WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      stop2_r   <= 1'b0;
      tx_out_r  <= 1'b1;
      busy_r    <= 1'b0;
      tx_done_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      shift_r   <= shift_nxt_s;
      cnt_r     <= cnt_nxt_s;
      tx_out_r  <= tx_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
      tx_done_r <= final_stop_s && !accept_s;
      if (accept_s) begin
        par_en_r  <= par_en;
        par_bit_r <= calc_parity(p_data, par_mode);
        stop2_r   <= stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Self-checking bench for uart_tx_frame_gen: bit-queue reference model plus directed frames.
module tb_uart_tx_frame_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] pd = 8'h00;
  logic       dv = 1'b0;
  logic       pe = 1'b0;
  logic [1:0] pm = 2'b00;
  logic       s2 = 1'b0;
  logic       tx_out, busy, ready, tx_done;

  int         total_cnt = 0;
  int         bad_cnt = 0;
  bit         exp_q[$];
  bit         exp_done = 1'b0;
  logic [15:0] hist = 16'h0000;

  uart_tx_frame_gen #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p_data     (pd),
    .data_valid (dv),
    .par_en     (pe),
    .par_mode   (pm),
    .stop2      (s2),
    .tx_out     (tx_out),
    .busy       (busy),
    .ready      (ready),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A frame is just the list of line levels it puts on the wire
  task automatic push_frame(input logic [7:0] d, input logic p_en, input logic [1:0] mode,
                            input logic two);
    bit par;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (p_en) begin
      case (mode)
        2'b00:   par = (($countones(d) % 2) == 1);
        2'b01:   par = (($countones(d) % 2) == 0);
        2'b10:   par = 1'b1;
        default: par = 1'b0;
      endcase
      exp_q.push_back(par);
    end
    exp_q.push_back(1'b1);
    if (two) exp_q.push_back(1'b1);
  endtask

  task automatic step();
    bit mready, acc, had_last, exp_tx;
    @(posedge clk);
    mready   = (exp_q.size() <= 1);
    acc      = dv && mready;
    had_last = (exp_q.size() == 1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    exp_done = had_last && !acc;
    if (acc) push_frame(pd, pe, pm, s2);
    #1;
    hist   = {hist[14:0], tx_out};
    exp_tx = (exp_q.size() > 0) ? exp_q[0] : 1'b1;
    check_val("tx_out", 32'(tx_out), 32'(exp_tx));
    check_val("busy", 32'(busy), 32'(exp_q.size() > 0));
    check_val("ready", 32'(ready), 32'(exp_q.size() <= 1));
    check_val("tx_done", 32'(tx_done), 32'(exp_done));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_val("rst_tx_out", 32'(tx_out), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_tx_done", 32'(tx_done), 32'd0);
    exp_q.delete();
    exp_done = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    dv = 1'b0;
    while (!ready && n < 40) begin
      step();
      n++;
    end
    check_val("ready_wait", 32'(ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic p_en, input logic [1:0] mode,
                      input logic two);
    wait_ready();
    pd = d; pe = p_en; pm = mode; s2 = two; dv = 1'b1;
    hist = 16'h0000;
    step();
    dv = 1'b0;
  endtask

  // Remaining bits of an 11-bit frame while mid-frame inputs wander
  task automatic run_rest(input int n);
    for (int i = 0; i < n; i++) begin
      pd = 8'($urandom); pe = 1'($urandom); pm = 2'($urandom); s2 = 1'($urandom);
      step();
    end
  endtask

  initial begin
    #1;
    do_reset();

    send(8'hA5, 1'b1, 2'b00, 1'b0);
    run_rest(10);
    check_val("seq_a5_even", 32'(hist[10:0]), 32'(11'b01010010101));
    run_rest(2);

    send(8'hA5, 1'b1, 2'b01, 1'b0);
    run_rest(10);
    check_val("par_odd", 32'(hist[1]), 32'd1);
    send(8'h00, 1'b1, 2'b10, 1'b0);
    run_rest(10);
    check_val("par_mark", 32'(hist[1]), 32'd1);
    send(8'hFF, 1'b1, 2'b11, 1'b0);
    run_rest(10);
    check_val("par_space", 32'(hist[1]), 32'd0);
    run_rest(2);

    send(8'h3C, 1'b0, 2'b00, 1'b1);
    run_rest(10);
    check_val("seq_3c_stop2", 32'(hist[10:0]), 32'(11'b00011110011));
    run_rest(2);

    // Back-to-back: 0xAA is held while 0x55 is on the line and lands in its final stop cycle
    wait_ready();
    pd = 8'h55; pe = 1'b1; pm = 2'b00; s2 = 1'b0; dv = 1'b1;
    step();
    pd = 8'hAA;
    repeat (10) step();
    hist = 16'h0000;
    step();
    check_val("b2b_start", 32'(tx_out), 32'd0);
    check_val("b2b_busy", 32'(busy), 32'd1);
    dv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dv = (i == 2);
      pd = 8'hFF;
      step();
    end
    dv = 1'b0;
    check_val("seq_aa_b2b", 32'(hist[10:0]), 32'(11'b00101010101));
    run_rest(2);

    // Reset in the middle of DATA, then a clean frame
    send(8'h5A, 1'b1, 2'b00, 1'b1);
    run_rest(4);
    do_reset();
    send(8'hA5, 1'b1, 2'b00, 1'b0);
    run_rest(10);
    check_val("seq_after_rst", 32'(hist[10:0]), 32'(11'b01010010101));
    run_rest(2);

    for (int i = 0; i < 600; i++) begin
      dv = ($urandom_range(0, 3) == 0);
      pd = 8'($urandom); pe = 1'($urandom); pm = 2'($urandom); s2 = 1'($urandom);
      if ($urandom_range(0, 249) == 0) do_reset();
      else step();
    end
    dv = 1'b0;
    repeat (15) step();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
